// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, register-index constants, write-back FSM states.
package y86_pkg;

    localparam int REG_AW = 4;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    localparam logic [REG_AW-1:0] RNONE = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_rd_bypass.sv
// One combinational decode read port: stored-file mux plus optional write-through compare.
module regfile_rd_bypass
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [REG_AW-1:0]               addr_i,
    input  logic                            we_i,
    input  logic [REG_AW-1:0]               dstE_i,
    input  logic [DATA_W-1:0]               valE_i,
    input  logic [REG_AW-1:0]               dstM_i,
    input  logic [DATA_W-1:0]               valM_i,
    output logic [DATA_W-1:0]               data_o
);

    localparam logic [REG_AW-1:0] NREG = REG_AW'(NUM_REGS);

    logic in_range;
    assign in_range = (addr_i < NREG);

    // Unimplemented indices read 0; a committing write (M over E) overrides stored data.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_i == REG_AW'(i)) data_o = regs_i[i];
        end
        if (BYPASS && we_i && in_range) begin
            if (addr_i == dstE_i) data_o = valE_i;
            if (addr_i == dstM_i) data_o = valM_i;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Y86 write-back stage: architectural register file, RUN/HALT status latch, retire counter.
module regfile_wb
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       W_valid,
    input  logic [2:0]                 W_stat,
    input  logic [REG_AW-1:0]          W_dstE,
    input  logic [DATA_W-1:0]          W_valE,
    input  logic [REG_AW-1:0]          W_dstM,
    input  logic [DATA_W-1:0]          W_valM,
    input  logic [REG_AW*NUM_RD-1:0]   rd_addr,
    output logic [DATA_W*NUM_RD-1:0]   rd_data,
    output logic                       halted,
    output logic [2:0]                 stat_out,
    output logic [CNT_W-1:0]           retired
);

    wb_state_e                      state_q, state_d;
    logic [2:0]                     stat_q, stat_d;
    logic [CNT_W-1:0]               retired_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    logic we;
    logic retire;

    assign we     = W_valid && (W_stat == AOK) && (state_q == RUN);
    assign retire = W_valid && (state_q == RUN) && ((W_stat == AOK) || (W_stat == HLT));

    // Next-state: the first non-AOK instruction latches its status and freezes the machine.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (state_q == RUN && W_valid && W_stat != AOK) begin
            state_d = HALT;
            stat_d  = W_stat;
        end
    end

    // Status/state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            stat_q  <= AOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    // Register commit; M is applied last so it wins an E/M index collision (popq %rsp).
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (W_dstM == REG_AW'(i))      regs_q[i] <= W_valM;
                else if (W_dstE == REG_AW'(i)) regs_q[i] <= W_valE;
            end
        end
    end

    // Saturating count of retired instructions; ADR/INS faults are not counted.
    always_ff @(posedge clk) begin
        if (rst)                           retired_q <= '0;
        else if (retire && retired_q != '1) retired_q <= retired_q + 1'b1;
    end

    assign halted   = (state_q == HALT);
    assign stat_out = stat_q;
    assign retired  = retired_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_bypass #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .BYPASS  (BYPASS)
        ) u_rd (
            .regs_i(regs_q),
            .addr_i(rd_addr[REG_AW*g +: REG_AW]),
            .we_i  (we),
            .dstE_i(W_dstE),
            .valE_i(W_valE),
            .dstM_i(W_dstM),
            .valM_i(W_valM),
            .data_o(rd_data[DATA_W*g +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: three configurations share one stimulus stream; a directed vector
// table targets the default instance, and an array-based model checks every instance.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_valid;
    logic [2:0]  W_stat;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [7:0]  rd_addr;

    logic [127:0] rd_b1, rd_b0, rd_n8;
    logic         h_b1, h_b0, h_n8;
    logic [2:0]   s_b1, s_b0, s_n8;
    logic [31:0]  r_b1, r_b0;
    logic [2:0]   r_n8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb #(.DATA_W(64), .NUM_REGS(15), .NUM_RD(2), .BYPASS(1'b1), .CNT_W(32)) u_b1 (
        .clk(clk), .rst(rst), .W_valid(W_valid), .W_stat(W_stat), .W_dstE(W_dstE),
        .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM), .rd_addr(rd_addr),
        .rd_data(rd_b1), .halted(h_b1), .stat_out(s_b1), .retired(r_b1));

    regfile_wb #(.DATA_W(64), .NUM_REGS(15), .NUM_RD(2), .BYPASS(1'b0), .CNT_W(32)) u_b0 (
        .clk(clk), .rst(rst), .W_valid(W_valid), .W_stat(W_stat), .W_dstE(W_dstE),
        .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM), .rd_addr(rd_addr),
        .rd_data(rd_b0), .halted(h_b0), .stat_out(s_b0), .retired(r_b0));

    regfile_wb #(.DATA_W(64), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1'b1), .CNT_W(3)) u_n8 (
        .clk(clk), .rst(rst), .W_valid(W_valid), .W_stat(W_stat), .W_dstE(W_dstE),
        .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM), .rd_addr(rd_addr),
        .rd_data(rd_n8), .halted(h_n8), .stat_out(s_n8), .retired(r_n8));

    // ---------------- reference model: plain arrays, one slot per instance ----------------
    int          nregs [3] = '{15, 15, 8};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    longint      cmax  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 7};
    logic [63:0] mreg  [3][16];
    bit          mhalt [3];
    logic [2:0]  mstat [3];
    longint      mret  [3];

    function automatic logic [63:0] model_read(int m, logic [3:0] a);
        bit commit;
        commit = W_valid && W_stat == 3'd1 && !mhalt[m];
        if (int'(a) >= nregs[m]) return 64'd0;
        if (byp[m] && commit) begin
            if (a == W_dstM) return W_valM;
            if (a == W_dstE) return W_valE;
        end
        return mreg[m][a];
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                for (int r = 0; r < 16; r++) mreg[m][r] = 64'd0;
                mhalt[m] = 1'b0;
                mstat[m] = 3'd1;
                mret[m]  = 0;
            end else if (!mhalt[m] && W_valid) begin
                if (W_stat == 3'd1) begin
                    if (int'(W_dstE) < nregs[m]) mreg[m][W_dstE] = W_valE;
                    if (int'(W_dstM) < nregs[m]) mreg[m][W_dstM] = W_valM;
                end else begin
                    mhalt[m] = 1'b1;
                    mstat[m] = W_stat;
                end
                if ((W_stat == 3'd1 || W_stat == 3'd2) && mret[m] < cmax[m]) mret[m]++;
            end
        end
    endtask

    task automatic chk(string nm, int m, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%h exp=%h", nm, m, got, exp);
        end
    endtask

    function automatic logic [127:0] get_rd(int m);
        case (m)
            0:       return rd_b1;
            1:       return rd_b0;
            default: return rd_n8;
        endcase
    endfunction

    task automatic check_model();
        logic [127:0] rd;
        for (int m = 0; m < 3; m++) begin
            rd = get_rd(m);
            for (int p = 0; p < 2; p++)
                chk("model_rd", m, rd[64*p +: 64], model_read(m, rd_addr[4*p +: 4]));
        end
        chk("model_halted", 0, 64'(h_b1), 64'(mhalt[0]));
        chk("model_halted", 1, 64'(h_b0), 64'(mhalt[1]));
        chk("model_halted", 2, 64'(h_n8), 64'(mhalt[2]));
        chk("model_stat",   0, 64'(s_b1), 64'(mstat[0]));
        chk("model_stat",   1, 64'(s_b0), 64'(mstat[1]));
        chk("model_stat",   2, 64'(s_n8), 64'(mstat[2]));
        chk("model_retired", 0, 64'(r_b1), 64'(mret[0]));
        chk("model_retired", 1, 64'(r_b0), 64'(mret[1]));
        chk("model_retired", 2, 64'(r_n8), 64'(mret[2]));
    endtask

    // One cycle: inputs already driven; check mid-cycle, then advance model with the edge.
    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table for the BYPASS=1, 15-register instance ----------------
    typedef struct {
        bit          r;
        bit          v;
        logic [2:0]  st;
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic [3:0]  a0, a1;
        logic [63:0] e0, e1;
        bit          eh;
        logic [2:0]  es;
        int          er;
    } vec_t;

    vec_t vq[$];

    task automatic addv(bit r, bit v, logic [2:0] st, logic [3:0] de, logic [63:0] ve,
                        logic [3:0] dm, logic [63:0] vm, logic [3:0] a0, logic [3:0] a1,
                        logic [63:0] e0, logic [63:0] e1, bit eh, logic [2:0] es, int er);
        vec_t t;
        t = '{r, v, st, de, ve, dm, vm, a0, a1, e0, e1, eh, es, er};
        vq.push_back(t);
    endtask

    initial begin
        rst = 1'b1; W_valid = 1'b0; W_stat = 3'd1; W_dstE = 4'hF; W_dstM = 4'hF;
        W_valE = '0; W_valM = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        model_edge();
        #1;

        //    r  v  st  dE   vE        dM   vM        a0   a1   e0        e1       eh es  ret
        addv(0, 1, 1, 4'd3, 64'h1234, 4'hF, 64'h0,    4'd3, 4'd5, 64'h1234, 64'h0,    0, 1, 0);
        addv(0, 1, 1, 4'hF, 64'h0,    4'd5, 64'hABCD, 4'd3, 4'd5, 64'h1234, 64'hABCD, 0, 1, 1);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd3, 4'd5, 64'h1234, 64'hABCD, 0, 1, 2);
        addv(0, 1, 1, 4'd4, 64'h100,  4'd4, 64'h200,  4'd4, 4'd3, 64'h200,  64'h1234, 0, 1, 2);
        addv(0, 1, 1, 4'd2, 64'h55,   4'hF, 64'h0,    4'd4, 4'd2, 64'h200,  64'h55,   0, 1, 3);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd2, 4'd4, 64'h55,   64'h200,  0, 1, 4);
        addv(0, 1, 3, 4'd1, 64'hFF,   4'hF, 64'h0,    4'd1, 4'd2, 64'h0,    64'h55,   0, 1, 4);
        addv(0, 1, 1, 4'd1, 64'h77,   4'hF, 64'h0,    4'd1, 4'd4, 64'h0,    64'h200,  1, 3, 4);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd1, 4'd2, 64'h0,    64'h55,   1, 3, 4);
        addv(1, 1, 1, 4'd6, 64'h66,   4'hF, 64'h0,    4'd6, 4'd1, 64'h0,    64'h0,    1, 3, 4);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd6, 4'd4, 64'h0,    64'h0,    0, 1, 0);
        addv(0, 1, 2, 4'd7, 64'h9,    4'hF, 64'h0,    4'd7, 4'd3, 64'h0,    64'h0,    0, 1, 0);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd7, 4'd3, 64'h0,    64'h0,    1, 2, 1);
        addv(1, 1, 1, 4'd6, 64'h66,   4'hF, 64'h0,    4'd6, 4'd0, 64'h0,    64'h0,    1, 2, 1);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd6, 4'd7, 64'h0,    64'h0,    0, 1, 0);
        addv(1, 1, 1, 4'd6, 64'h66,   4'hF, 64'h0,    4'd6, 4'd0, 64'h66,   64'h0,    0, 1, 0);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'd6, 4'd0, 64'h0,    64'h0,    0, 1, 0);
        addv(0, 1, 1, 4'hA, 64'h5A5A, 4'hF, 64'h0,    4'hA, 4'd3, 64'h5A5A, 64'h0,    0, 1, 0);
        addv(0, 0, 1, 4'hF, 64'h0,    4'hF, 64'h0,    4'hA, 4'd3, 64'h5A5A, 64'h0,    0, 1, 1);

        foreach (vq[i]) begin
            rst = vq[i].r; W_valid = vq[i].v; W_stat = vq[i].st;
            W_dstE = vq[i].de; W_valE = vq[i].ve; W_dstM = vq[i].dm; W_valM = vq[i].vm;
            rd_addr = {vq[i].a1, vq[i].a0};
            #1;
            chk("vec_rd0",     i, rd_b1[63:0],   vq[i].e0);
            chk("vec_rd1",     i, rd_b1[127:64], vq[i].e1);
            chk("vec_halted",  i, 64'(h_b1),     64'(vq[i].eh));
            chk("vec_stat",    i, 64'(s_b1),     64'(vq[i].es));
            chk("vec_retired", i, 64'(r_b1),     64'(vq[i].er));
            cycle();
        end

        // BYPASS=0 latency: old value during the write cycle, new value on the next.
        rst = 1'b0; W_valid = 1'b1; W_stat = 3'd1; W_dstE = 4'd2; W_valE = 64'h55;
        W_dstM = 4'hF; rd_addr = {4'd2, 4'd2};
        #1;
        chk("b0_same_cycle_old", 1, rd_b0[63:0], 64'h0);
        chk("b1_same_cycle_new", 0, rd_b1[63:0], 64'h55);
        cycle();
        W_valid = 1'b0;
        #1;
        chk("b0_next_cycle_new", 1, rd_b0[63:0], 64'h55);
        cycle();

        // Randomized traffic across all three configurations.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            W_valid = ($urandom_range(0, 3) != 0);
            W_stat  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            W_dstE  = 4'($urandom_range(0, 15));
            W_dstM  = ($urandom_range(0, 2) == 0) ? W_dstE : 4'($urandom_range(0, 15));
            W_valE  = {$urandom, $urandom};
            W_valM  = {$urandom, $urandom};
            rd_addr = 8'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
